vn_accum_sched: RTL and testbench
=================================

VN_ACCUM_SCHED -- requirements
Module: vn_accum_sched

Interface
REQ-001 Parameter WIDTH, default 8, message/LLR width in bits (two's complement).
REQ-002 Parameter EXTENDED_BITS, default 4, guard bits of the internal accumulator.
REQ-003 Parameter DEGREE, default 3, check-node messages summed per variable node; legal range 1 to 2**EXTENDED_BITS-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a new variable-node update; sampled only in IDLE.
REQ-007 llr_in  input  WIDTH  signed channel LLR, captured on the cycle start is accepted.
REQ-008 msg_valid  input  1  msg_in holds a valid check message.
REQ-009 msg_in  input  WIDTH  signed check-node message.
REQ-010 msg_ready  output  1  block accepts msg_in this cycle.
REQ-011 flush  input  1  synchronous abort of the current update.
REQ-012 out_valid  output  1  out_total is valid.
REQ-013 out_ready  input  1  consumer accepts out_total.
REQ-014 out_total  output  WIDTH  saturated sum, signed.
REQ-015 sat_flag  output  1  out_total was clipped.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 sat_count  output  16  running count of clipped results.

Function
REQ-018 FSM states: IDLE, ACCUM, OUT; encoding free.
REQ-019 IDLE: start=1 -> acc <= sign-extended llr_in, msg count <= 0, go to ACCUM; start=0 -> stay.
REQ-020 Accumulator acc is WIDTH+EXTENDED_BITS bits signed; every operand sign-extended; no wrap is possible under REQ-003.
REQ-021 ACCUM: msg_ready=1; msg accepted when msg_valid & msg_ready; each accept: acc += sign-extended msg_in, count += 1.
REQ-022 Accepting the DEGREE-th message -> go to OUT; out_valid is high on the next cycle (latency 1 after the last message).
REQ-023 On entry to OUT, out_total and sat_flag are registered from acc by the saturation rule REQ-024/025 and held stable until out_valid drops.
REQ-024 Top EXTENDED_BITS+1 bits of acc all 0 or all 1 -> out_total = acc[WIDTH-1:0], sat_flag=0.
REQ-025 Otherwise: acc positive -> out_total = 2**(WIDTH-1)-1; acc negative -> out_total = -(2**(WIDTH-1)-1) (symmetric, never the most negative code); sat_flag=1.
REQ-026 The most negative code (-2**(WIDTH-1)) is reachable only by pass-through from REQ-024; it is not a saturation.
REQ-027 OUT: out_valid=1; out_valid & out_ready -> IDLE next cycle; out_ready=0 -> hold all outputs unchanged.
REQ-028 sat_count increments by 1 on the cycle of entry to OUT with sat_flag=1; holds at 16'hFFFF (no wrap).
REQ-029 start outside IDLE is ignored; msg_ready=0 outside ACCUM.
REQ-030 flush=1 in any state -> IDLE next cycle; partial acc discarded; out_valid drops; sat_count unchanged; flush dominates start, msg and out handshakes in the same cycle.
REQ-031 msg_ready is a function of state only, with no combinational path from msg_valid.

Reset
REQ-032 rst_n low at any time, including mid-operation -> state IDLE; acc, count, out_total, sat_flag, sat_count = 0; out_valid, msg_ready, busy = 0.
REQ-033 Operation resumes on the first rising clk edge after rst_n deasserts; no start is captured during reset.

Verification (WIDTH=8, EXTENDED_BITS=4, DEGREE=3)
REQ-034 Nominal: llr=10, msgs 20, -5, 7 back to back -> out_valid one cycle after third accept, out_total=32, sat_flag=0, sat_count=0.
REQ-035 Positive clip: llr=127, msgs 127, 127, 127 (acc=508) -> out_total=127 (0x7F), sat_flag=1, sat_count=1.
REQ-036 Negative clip and boundary: llr=-128, msgs -128 x3 -> out_total=-127 (0x81), sat_flag=1; then llr=-128, msgs 0, 0, 0 -> out_total=-128 (0x80), sat_flag=0.
REQ-037 Backpressure and gaps: msg_valid toggled 1/0; out_ready low 5 cycles; start pulsed during OUT -> out_total stable, start ignored, single result, IDLE after out_ready.
REQ-038 Abort and reset: flush after 1 message -> IDLE, no out_valid, sat_count unchanged; rst_n low during ACCUM -> all outputs 0; fresh update afterwards gives correct sum.
REQ-039 Counter ceiling: force 65536 clipped results -> sat_count holds 16'hFFFF.

Source files
------------

// File: rtl/vn_accum_sched.sv
// rtl/vn_accum_sched.sv - LDPC variable-node accumulator with symmetric saturation and handshake scheduling
module vn_accum_sched #(
    parameter int WIDTH         = 8,
    parameter int EXTENDED_BITS = 4,
    parameter int DEGREE        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] llr_in,
    input  logic             msg_valid,
    input  logic [WIDTH-1:0] msg_in,
    output logic             msg_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_total,
    output logic             sat_flag,
    output logic             busy,
    output logic [15:0]      sat_count
);

    localparam int AW = WIDTH + EXTENDED_BITS;

    // Count value held while the final message of an update is being accepted
    localparam logic [EXTENDED_BITS-1:0] LAST_CNT = EXTENDED_BITS'(DEGREE - 1);
    localparam logic [EXTENDED_BITS-1:0] CNT_ONE  = EXTENDED_BITS'(1);

    // Symmetric clip limits; the most negative code is deliberately excluded
    localparam logic [WIDTH-1:0] POS_LIMIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_LIMIT = ~POS_LIMIT + {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_e;

    state_e                   state_q;
    logic [AW-1:0]            acc_q;
    logic [EXTENDED_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]         out_total_q;
    logic                     sat_flag_q;
    logic [15:0]              sat_count_q;

    logic [AW-1:0]            llr_ext;
    logic [AW-1:0]            msg_ext;
    logic [AW-1:0]            acc_sum_d;
    logic [EXTENDED_BITS:0]   acc_top;
    logic [WIDTH-1:0]         sat_total_d;
    logic                     sat_hit_d;
    logic                     last_msg;

    // Operands are sign-extended so two's-complement addition of the wider words cannot wrap
    assign llr_ext   = {{EXTENDED_BITS{llr_in[WIDTH-1]}}, llr_in};
    assign msg_ext   = {{EXTENDED_BITS{msg_in[WIDTH-1]}}, msg_in};
    assign acc_sum_d = acc_q + msg_ext;
    assign acc_top   = acc_sum_d[AW-1:WIDTH-1];
    assign last_msg  = (cnt_q == LAST_CNT);

    // Clip the running sum that would exist after accepting the current message
    always_comb begin
        sat_total_d = acc_sum_d[WIDTH-1:0];
        sat_hit_d   = 1'b0;
        if (!((&acc_top) || (~|acc_top))) begin
            sat_hit_d   = 1'b1;
            sat_total_d = acc_sum_d[AW-1] ? NEG_LIMIT : POS_LIMIT;
        end
    end

    // Control FSM with accumulator, result and clip counter; flush overrides every handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_total_q <= '0;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= llr_ext;
                        cnt_q   <= '0;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (msg_valid) begin
                        acc_q <= acc_sum_d;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (last_msg) begin
                            state_q     <= S_OUT;
                            out_total_q <= sat_total_d;
                            sat_flag_q  <= sat_hit_d;
                            if (sat_hit_d && (sat_count_q != 16'hFFFF)) begin
                                sat_count_q <= sat_count_q + 16'd1;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the state register only, so msg_ready never depends on msg_valid
    assign msg_ready = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign out_total = out_total_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_vn_accum_sched.sv
// tb/tb_vn_accum_sched.sv - directed self-checking bench for vn_accum_sched
module tb_vn_accum_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  llr_in;
    logic        msg_valid;
    logic [7:0]  msg_in;
    logic        msg_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_total;
    logic        sat_flag;
    logic        busy;
    logic [15:0] sat_count;

    int checks   = 0;
    int failures = 0;

    vn_accum_sched #(
        .WIDTH(8),
        .EXTENDED_BITS(4),
        .DEGREE(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .llr_in(llr_in),
        .msg_valid(msg_valid),
        .msg_in(msg_in),
        .msg_ready(msg_ready),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_total(out_total),
        .sat_flag(sat_flag),
        .busy(busy),
        .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_upd(input logic [7:0] llr);
        start  = 1'b1;
        llr_in = llr;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m);
        msg_valid = 1'b1;
        msg_in    = m;
        tick();
        msg_valid = 1'b0;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        llr_in    = '0;
        msg_valid = 1'b0;
        msg_in    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_msg_ready", 32'(msg_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out_total", 32'(out_total), 32'h0);
        chk("rst_sat_flag", 32'(sat_flag), 32'h0);
        chk("rst_sat_count", 32'(sat_count), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy), 32'h0);

        // Nominal: 10 + 20 - 5 + 7 = 32
        begin_upd(8'd10);
        chk("nom_msg_ready", 32'(msg_ready), 32'h1);
        chk("nom_busy", 32'(busy), 32'h1);
        send_msg(8'd20);
        send_msg(8'hFB);
        chk("nom_no_early_valid", 32'(out_valid), 32'h0);
        send_msg(8'd7);
        chk("nom_out_valid", 32'(out_valid), 32'h1);
        chk("nom_msg_ready_out", 32'(msg_ready), 32'h0);
        chk("nom_total", 32'(out_total), 32'h20);
        chk("nom_sat_flag", 32'(sat_flag), 32'h0);
        chk("nom_sat_count", 32'(sat_count), 32'h0);
        take_out();
        chk("nom_done_valid", 32'(out_valid), 32'h0);
        chk("nom_done_busy", 32'(busy), 32'h0);

        // Positive clip: 127 * 4 = 508
        begin_upd(8'd127);
        send_msg(8'd127);
        send_msg(8'd127);
        send_msg(8'd127);
        chk("pclip_total", 32'(out_total), 32'h7F);
        chk("pclip_flag", 32'(sat_flag), 32'h1);
        chk("pclip_count", 32'(sat_count), 32'h1);
        take_out();

        // Negative clip: -128 * 4 = -512 -> symmetric limit -127
        begin_upd(8'h80);
        send_msg(8'h80);
        send_msg(8'h80);
        send_msg(8'h80);
        chk("nclip_total", 32'(out_total), 32'h81);
        chk("nclip_flag", 32'(sat_flag), 32'h1);
        chk("nclip_count", 32'(sat_count), 32'h2);
        take_out();

        // Boundary: -128 passes through unclipped
        begin_upd(8'h80);
        send_msg(8'h00);
        send_msg(8'h00);
        send_msg(8'h00);
        chk("bnd_total", 32'(out_total), 32'h80);
        chk("bnd_flag", 32'(sat_flag), 32'h0);
        chk("bnd_count", 32'(sat_count), 32'h2);
        take_out();

        // Gaps and backpressure: 5 + 1 + 2 + 3 = 11
        begin_upd(8'd5);
        send_msg(8'd1);
        chk("gap_ready", 32'(msg_ready), 32'h1);
        tick();
        send_msg(8'd2);
        tick();
        chk("gap_no_valid", 32'(out_valid), 32'h0);
        send_msg(8'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_total", 32'(out_total), 32'h0B);
            chk("bp_msg_ready", 32'(msg_ready), 32'h0);
            start     = (i == 2);
            msg_valid = (i == 3);
            tick();
        end
        start     = 1'b0;
        msg_valid = 1'b0;
        chk("bp_still_valid", 32'(out_valid), 32'h1);
        chk("bp_still_total", 32'(out_total), 32'h0B);
        take_out();
        chk("bp_done_valid", 32'(out_valid), 32'h0);
        chk("bp_done_busy", 32'(busy), 32'h0);
        tick();
        chk("bp_start_ignored", 32'(busy), 32'h0);
        chk("bp_sat_count", 32'(sat_count), 32'h2);

        // Flush after one message, with a concurrent message handshake
        begin_upd(8'd3);
        send_msg(8'd4);
        flush     = 1'b1;
        msg_valid = 1'b1;
        msg_in    = 8'd9;
        tick();
        flush     = 1'b0;
        msg_valid = 1'b0;
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ready", 32'(msg_ready), 32'h0);
        chk("flush_count", 32'(sat_count), 32'h2);
        flush  = 1'b1;
        start  = 1'b1;
        llr_in = 8'd1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        chk("flush_over_start", 32'(busy), 32'h0);

        // Fresh update after flush discards the partial sum: 1 + 1 + 1 + 1 = 4
        begin_upd(8'd1);
        send_msg(8'd1);
        send_msg(8'd1);
        send_msg(8'd1);
        chk("post_flush_total", 32'(out_total), 32'h04);
        take_out();

        // Asynchronous reset during ACCUM
        begin_upd(8'd50);
        send_msg(8'd60);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ready", 32'(msg_ready), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_total", 32'(out_total), 32'h0);
        chk("arst_flag", 32'(sat_flag), 32'h0);
        chk("arst_count", 32'(sat_count), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh update: -3 - 4 - 2 + 1 = -8
        begin_upd(8'hFD);
        send_msg(8'hFC);
        send_msg(8'hFE);
        send_msg(8'h01);
        chk("fresh_total", 32'(out_total), 32'hF8);
        chk("fresh_flag", 32'(sat_flag), 32'h0);
        chk("fresh_count", 32'(sat_count), 32'h0);
        take_out();

        // Counter ceiling: preload near the top, then three clipped results
        force dut.sat_count_q = 16'hFFFD;
        #1;
        release dut.sat_count_q;
        #1;
        chk("ceil_preload", 32'(sat_count), 32'hFFFD);
        for (int k = 0; k < 3; k++) begin
            begin_upd(8'd127);
            send_msg(8'd127);
            send_msg(8'd127);
            send_msg(8'd127);
            chk("ceil_flag", 32'(sat_flag), 32'h1);
            chk("ceil_count", 32'(sat_count), (k == 0) ? 32'hFFFE : 32'hFFFF);
            take_out();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
